// File: rtl/data_receiver_pkg.sv
// Shared definitions for the serial word receiver.
// Holds the byte-deframer state encoding, frame geometry constants and the
// default timing parameters used by serial_receiver and data_receiver.
package data_receiver_pkg;

  // Byte deframer states.
  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  // 8N1 frame: 8 data bits; a word is 8 bytes, byte 0 in the low lane.
  localparam int unsigned DataBits     = 8;
  localparam int unsigned BytesPerWord = 8;
  localparam int unsigned WordBits     = DataBits * BytesPerWord;

  localparam int unsigned DefClksPerBit  = 16;
  localparam int unsigned DefTimeoutBits = 20;

endpackage

// File: rtl/serial_receiver.sv
// 8N1 byte deframer with input synchronizer.
// Ports:
//   clk          - system clock (rising edge)
//   rst_n        - asynchronous active-low reset
//   in_data      - raw serial line, idle high, asynchronous to clk
//   byte_out     - last received byte (valid while byte_done is high)
//   byte_done    - one-cycle pulse when a byte with a good stop bit completes
//   frame_error  - one-cycle pulse when the stop bit samples low
//   transmission - high while a frame is being decoded (not in idle)
module serial_receiver
  import data_receiver_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefClksPerBit
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_data,
  output logic [DataBits-1:0] byte_out,
  output logic                byte_done,
  output logic                frame_error,
  output logic                transmission
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);

  rx_state_e           state_q, state_d;
  logic [1:0]          sync_q;
  logic                prev_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [DataBits-1:0] shreg_q, shreg_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                ferr_q, ferr_d;
  logic                rx;

  assign rx = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (hold_q) begin
          // After a framing error, demand one full bit time of idle line
          // before any falling edge counts as a start bit again.
          if (rx) begin
            if (cnt_q == FullM1) begin
              hold_d = 1'b0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end else if (prev_q && !rx) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == HalfM1) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rx ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          shreg_d = {rx, shreg_q[DataBits-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        if (cnt_q == FullM1) begin
          cnt_d   = '0;
          state_d = StIdle;
          if (rx) begin
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
            hold_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], in_data};
      prev_q  <= rx;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign byte_out     = shreg_q;
  assign byte_done    = done_q;
  assign frame_error  = ferr_q;
  assign transmission = (state_q != StIdle);

endmodule

// File: rtl/data_receiver.sv
// Serial 64-bit word receiver: collects eight 8N1 bytes (byte 0 first) into
// one word, publishes it on data with a one-cycle valid pulse, and drops a
// partial word on a framing error or an over-long gap between bytes.
// Ports:
//   clk, rst_n   - clock and asynchronous active-low reset
//   in_data      - raw serial line, idle high
//   data         - last complete word; byte k is data[8k+7:8k]
//   valid        - one-cycle pulse when data updates
//   busy         - high while a word is partially received
//   transmission - high while a byte frame is in progress
//   error        - one-cycle pulse on framing error or inter-byte timeout
module data_receiver
  import data_receiver_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
  parameter int unsigned TIMEOUT_BITS = DefTimeoutBits
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_data,
  output logic [WordBits-1:0] data,
  output logic                valid,
  output logic                busy,
  output logic                transmission,
  output logic                error
);

  localparam int unsigned TimeoutLimit = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TmrW = $clog2(TimeoutLimit + 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TimeoutLimit - 1);

  logic [DataBits-1:0] byte_out;
  logic                byte_done;
  logic                frame_error;

  logic [WordBits-1:0] word_q, word_d;
  logic [WordBits-1:0] data_q, data_d;
  logic [2:0]          idx_q, idx_d;
  logic [TmrW-1:0]     tmr_q, tmr_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;

  serial_receiver #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serial_receiver (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .byte_out    (byte_out),
    .byte_done   (byte_done),
    .frame_error (frame_error),
    .transmission(transmission)
  );

  always_comb begin
    word_d  = word_q;
    data_d  = data_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    if (byte_done) begin
      // Completion has priority over a timeout expiring in the same cycle.
      word_d[{idx_q, 3'b000} +: DataBits] = byte_out;
      idx_d = idx_q + 3'd1;
      tmr_d = '0;
      if (idx_q == 3'd7) begin
        data_d  = {byte_out, word_q[WordBits-DataBits-1:0]};
        valid_d = 1'b1;
      end
    end else if (frame_error) begin
      idx_d   = '0;
      tmr_d   = '0;
      error_d = 1'b1;
    end else if (transmission || (idx_q == 3'd0)) begin
      // A frame in progress restarts the gap measurement.
      tmr_d = '0;
    end else if (tmr_q == TmrLast) begin
      idx_d   = '0;
      tmr_d   = '0;
      error_d = 1'b1;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign error = error_q;
  assign busy  = (idx_q != 3'd0);

endmodule

// File: tb/tb_data_receiver.sv
module tb_data_receiver;

  localparam int unsigned Cpb = 4;
  localparam int unsigned Tob = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_data = 1'b1;
  logic [63:0] data;
  logic        valid, busy, transmission, error;

  always #5 clk = ~clk;

  data_receiver #(
    .CLKS_PER_BIT(Cpb),
    .TIMEOUT_BITS(Tob)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .data        (data),
    .valid       (valid),
    .busy        (busy),
    .transmission(transmission),
    .error       (error)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: bytes of the word being collected, words expected on
  // valid (in order), and error pulses still owed by the DUT.
  logic [7:0]  part[$];
  logic [63:0] exp_words[$];
  int          pend_err = 0;
  int          valid_seen = 0;
  int          err_seen = 0;
  int          last_err_cyc = 0;
  logic [63:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_data = '0;
    end else begin
      chk("valid_error_exclusive", {63'd0, valid & error}, 64'd0);
      if (valid) begin
        valid_seen++;
        chk("valid_expected", {63'd0, exp_words.size() > 0}, 64'd1);
        if (exp_words.size() > 0) chk("word", data, exp_words.pop_front());
      end else begin
        chk("data_hold", data, last_data);
      end
      if (error) begin
        err_seen++;
        last_err_cyc = cyc;
        chk("error_expected", {63'd0, pend_err > 0}, 64'd1);
        if (pend_err > 0) pend_err--;
      end
      last_data = data;
    end
  end

  task automatic bit_time(input logic v);
    in_data = v;
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_data", data, 64'd0);
    chk("rst_valid", {63'd0, valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_transmission", {63'd0, transmission}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);
    part.delete();
    exp_words.delete();
    pend_err = 0;
    in_data = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Sends one frame. abort_bit >= 0 asserts reset halfway through that data bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_bit);
    logic        busy_exp;
    logic [63:0] w;
    busy_exp = (part.size() != 0);
    if (abort_bit < 0) begin
      if (stop) begin
        part.push_back(b);
        if (part.size() == 8) begin
          w = '0;
          for (int i = 0; i < 8; i++) w[8*i +: 8] = part[i];
          exp_words.push_back(w);
          part.delete();
        end
      end else begin
        pend_err++;
        part.delete();
      end
    end
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_bit) begin
        in_data = b[i];
        repeat (Cpb / 2) @(negedge clk);
        do_reset();
        return;
      end
      bit_time(b[i]);
      if (i == 3) chk("busy_mid_frame", {63'd0, busy}, {63'd0, busy_exp});
    end
    bit_time(stop);
    in_data = 1'b1;
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b1, -1);
  endtask

  // Idle line; the model owes a timeout error when a partial word sits idle
  // well past TIMEOUT_BITS bit times.
  task automatic gap(input int n);
    if (part.size() != 0 && n >= 90) begin
      pend_err++;
      part.delete();
    end
    in_data = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic settle(input string name);
    gap(12);
    chk({name, "_words_drained"}, exp_words.size(), 64'd0);
    chk({name, "_errors_drained"}, pend_err, 64'd0);
  endtask

  int v0, e0, t0;
  int wd;
  logic saw_tx;
  logic [7:0] rb;

  initial begin
    // Reset state.
    @(negedge clk);
    do_reset();

    // Back-to-back word.
    v0 = valid_seen;
    good(8'hEF); good(8'hCD); good(8'hAB); good(8'h89);
    good(8'h67); good(8'h45); good(8'h23); good(8'h01);
    settle("word1");
    chk("word1_data", data, 64'h0123456789ABCDEF);
    chk("word1_one_valid", valid_seen - v0, 64'd1);
    chk("word1_busy_after", {63'd0, busy}, 64'd0);

    // One-cycle glitch on the idle line.
    e0 = err_seen;
    saw_tx = 1'b0;
    in_data = 1'b0;
    @(negedge clk);
    in_data = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (transmission) saw_tx = 1'b1;
    end
    chk("glitch_started", {63'd0, saw_tx}, 64'd1);
    chk("glitch_tx_back", {63'd0, transmission}, 64'd0);
    gap(10);
    chk("glitch_no_error", err_seen - e0, 64'd0);
    chk("glitch_busy", {63'd0, busy}, 64'd0);

    // Framing error after three bytes, then a clean word.
    e0 = err_seen;
    good(8'h31); good(8'h32); good(8'h33);
    send_frame(8'h5A, 1'b0, -1);
    gap(12);
    chk("ferr_one_error", err_seen - e0, 64'd1);
    chk("ferr_busy", {63'd0, busy}, 64'd0);
    chk("ferr_data_kept", data, 64'h0123456789ABCDEF);
    for (int i = 0; i < 8; i++) good(8'($urandom));
    settle("ferr_recover");

    // Inter-byte timeout after five bytes.
    v0 = valid_seen;
    e0 = err_seen;
    for (int i = 0; i < 5; i++) good(8'($urandom));
    t0 = cyc;
    gap(100);
    chk("tmo_one_error", err_seen - e0, 64'd1);
    chk("tmo_window", {63'd0, (last_err_cyc - t0) >= 78 && (last_err_cyc - t0) <= 90}, 64'd1);
    chk("tmo_no_valid", valid_seen - v0, 64'd0);
    chk("tmo_busy", {63'd0, busy}, 64'd0);

    // Gap below the timeout keeps the partial word.
    v0 = valid_seen;
    e0 = err_seen;
    good(8'hC0); good(8'hC1);
    gap(70);
    for (int i = 2; i < 8; i++) good(8'(8'hC0 + i));
    settle("short_gap");
    chk("short_gap_no_error", err_seen - e0, 64'd0);
    chk("short_gap_data", data, 64'hC7C6C5C4C3C2C1C0);

    // Reset during bit 4 of byte 6, then a fresh word.
    for (int i = 0; i < 5; i++) good(8'($urandom));
    send_frame(8'hA5, 1'b1, 4);
    v0 = valid_seen;
    for (int i = 1; i <= 8; i++) good(8'(i * 8'h11));
    settle("post_reset");
    chk("post_reset_data", data, 64'h8877665544332211);
    chk("post_reset_one_valid", valid_seen - v0, 64'd1);

    // Two consecutive words; the first holds until the second completes.
    v0 = valid_seen;
    for (int i = 0; i < 8; i++) good(8'(8'h10 + i));
    for (int i = 0; i < 4; i++) good(8'(8'hA0 + i));
    chk("two_words_hold", data, 64'h1716151413121110);
    for (int i = 4; i < 8; i++) good(8'(8'hA0 + i));
    settle("two_words");
    chk("two_words_data", data, 64'hA7A6A5A4A3A2A1A0);
    chk("two_words_valids", valid_seen - v0, 64'd2);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 11) == 0) begin
        send_frame(rb, 1'b0, -1);
        gap($urandom_range(8, 30));
      end else begin
        good(rb);
        if ($urandom_range(0, 14) == 0) wd = $urandom_range(95, 120);
        else wd = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
        gap(wd);
      end
    end
    settle("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout want finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_receiver.md
DATA_RECEIVER -- requirements
Module: data_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal values are even and >= 4.
REQ-002 SHALL have parameter TIMEOUT_BITS, default 20: maximum idle gap, in bit times, between bytes of one word.
REQ-003 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_data  input  1  serial line, idle high, asynchronous to clk.
REQ-006 SHALL have port data  output  64  last complete word; byte k is data[8k+7:8k].
REQ-007 SHALL have port valid  output  1  one-cycle pulse when data updates.
REQ-008 SHALL have port busy  output  1  high while a word is partially received (byte index != 0).
REQ-009 SHALL have port transmission  output  1  high while a byte frame is in progress.
REQ-010 SHALL have port error  output  1  one-cycle pulse on framing error or timeout.

Function
REQ-011 SHALL pass in_data through a 2-flop synchronizer (reset value 1) before any use.
REQ-012 SHALL decode frames as: start bit 0, 8 data bits LSB first, stop bit 1 (8N1).
REQ-013 SHALL implement the byte FSM with states IDLE, START, DATA, STOP.
REQ-014 IDLE->START SHALL occur on a synchronized 1->0 transition.
REQ-015 START SHALL re-sample the line at CLKS_PER_BIT/2 cycles; if it reads 1, return to IDLE (glitch rejected, no error); if 0, go to DATA.
REQ-016 DATA SHALL sample each bit every CLKS_PER_BIT cycles after the start mid-point, 8 samples, via a 3-bit bit counter.
REQ-017 STOP SHALL sample one bit time after the last data bit; on 1 the byte is complete; on 0 a framing error is raised.
REQ-018 A completed byte SHALL be written into word slot byte_index (0..7), and byte_index SHALL increment.
REQ-019 When slot 7 completes, the 64-bit word SHALL update data and pulse valid in the next clk cycle, and byte_index SHALL wrap to 0.
REQ-020 data SHALL hold its value until the next complete word; partial words never appear on data.
REQ-021 On a framing error, the receiver SHALL pulse error, discard the partial word (byte_index<=0), and stay in IDLE until the line reads 1 for one full bit time.
REQ-022 A timeout counter SHALL run while busy=1 and the FSM is in IDLE; when it reaches TIMEOUT_BITS*CLKS_PER_BIT, error SHALL pulse and byte_index SHALL reset to 0.
REQ-023 The timeout counter SHALL clear whenever a start bit is accepted.
REQ-024 If a stop-bit completion and a timeout expiry fall on the same cycle, byte completion SHALL win and no error SHALL pulse.
REQ-025 transmission SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-026 valid and error SHALL never both be high in the same cycle.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately force the FSM to IDLE, all counters to 0, byte_index to 0, data to 0, valid/error/busy/transmission to 0, and the synchronizer flops to 1.
REQ-028 A reset asserted mid-frame or mid-word SHALL discard all partial data, and no valid SHALL follow release.
REQ-029 After reset release, the first falling edge SHALL be treated as a fresh start bit.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE/START/DATA/STOP), the frame constants (8 data bits, 8 bytes per word), and the default CLKS_PER_BIT/TIMEOUT_BITS values.
REQ-031 Byte deframing SHALL be one sub-module, serial_receiver (clk, rst_n, in_data, byte_out[7:0], byte_done, frame_error, transmission); data_receiver instantiates it once and contains the word assembler and timeout logic.

Verification (CLKS_PER_BIT=4, TIMEOUT_BITS=20)
REQ-032 Send bytes 0xEF,0xCD,0xAB,0x89,0x67,0x45,0x23,0x01 back-to-back -> exactly one valid pulse, data=64'h0123456789ABCDEF, busy high from first byte until valid.
REQ-033 A 1-cycle low glitch on idle in_data -> transmission returns to 0 within 3 cycles, no error, byte_index stays 0.
REQ-034 Send 3 bytes, then a byte with stop bit 0 -> one error pulse, busy=0, data unchanged; then 8 good bytes -> correct word on valid.
REQ-035 Send 5 bytes, then idle for 81 cycles -> error pulses exactly once at 80 idle cycles, busy=0, no valid.
REQ-036 Assert rst_n low during bit 4 of byte 6, then release and send 8 bytes 0x11..0x88 -> data=64'h8877665544332211, one valid.
REQ-037 Send two consecutive words -> two valid pulses, data holds word 1 until word 2 completes.
